// File: rtl/spi_arb_pkg.sv
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared state encoding, default byte width and timeout-counter
//               sizing for the SPI bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_arb_pkg;

    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Bits needed to hold 0..timeout, never less than one.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way combinational round-robin grant; the requester that
//               was not served last wins a contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
// ============================================================================
// Module      : spi_bus_arbiter
// Description : Shares one SPI master between two byte requesters: arbitrate,
//               start, wait with timeout, return the read byte to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] tx_data0,
    input  logic [DATA_W-1:0] tx_data1,
    input  logic              slave0,
    input  logic              slave1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              err,
    output logic              busy,
    input  logic              m_ready,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rx,
    output logic              m_start,
    output logic [DATA_W-1:0] m_data,
    output logic              m_slave
);

    localparam int                 c_cnt_w   = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_slave_q, m_slave_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                err_pend_q, err_pend_d;

    logic [1:0]          w_gnt;
    logic                w_expired;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (w_gnt)
    );

    // The counter holds the number of WAIT cycles already spent; aborting
    // once it reaches TIMEOUT places the error ack TIMEOUT+2 cycles after
    // the start pulse, leaving the master TIMEOUT+1 WAIT cycles to answer.
    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_expired = (cnt_q == c_cnt_lim);
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        m_data_d   = m_data_q;
        m_slave_d  = m_slave_q;
        rx_data_d  = rx_data_q;
        err_pend_d = err_pend_q;

        case (state_q)
            ST_IDLE: begin
                if ((w_gnt != 2'b00) && m_ready) begin
                    win_d     = w_gnt[1];
                    m_data_d  = w_gnt[1] ? tx_data1 : tx_data0;
                    m_slave_d = w_gnt[1] ? slave1 : slave0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final timeout cycle still counts as good.
                if (m_done) begin
                    rx_data_d  = m_rx;
                    err_pend_d = 1'b0;
                    state_d    = ST_DONE;
                end else if (w_expired) begin
                    rx_data_d  = '0;
                    err_pend_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (cnt_q != {c_cnt_w{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            win_q      <= 1'b0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_slave_q  <= 1'b0;
            rx_data_q  <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_slave_q  <= m_slave_d;
            rx_data_q  <= rx_data_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign m_start = (state_q == ST_START);
    assign busy    = (state_q != ST_IDLE);
    assign ack     = (state_q == ST_DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign err     = (state_q == ST_DONE) && err_pend_q;
    assign m_data  = m_data_q;
    assign m_slave = m_slave_q;
    assign rx_data = rx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
// ============================================================================
// Module      : tb_spi_bus_arbiter
// Description : Self-checking bench for spi_bus_arbiter with a stub SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_bus_arbiter;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] tx_data0 = 8'h00;
    logic [7:0] tx_data1 = 8'h00;
    logic       slave0 = 1'b0;
    logic       slave1 = 1'b0;
    logic [1:0] ack;
    logic [7:0] rx_data;
    logic       err;
    logic       busy;
    logic       m_ready = 1'b1;
    logic       m_done = 1'b0;
    logic [7:0] m_rx = 8'h00;
    logic       m_start;
    logic [7:0] m_data;
    logic       m_slave;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    int         stub_delay = 1;
    logic [7:0] stub_rx = 8'h00;
    bit         stub_early = 1'b0;
    int         stub_cnt = 0;

    spi_bus_arbiter #(.DATA_W(8), .TIMEOUT(T)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .tx_data0 (tx_data0),
        .tx_data1 (tx_data1),
        .slave0   (slave0),
        .slave1   (slave1),
        .ack      (ack),
        .rx_data  (rx_data),
        .err      (err),
        .busy     (busy),
        .m_ready  (m_ready),
        .m_done   (m_done),
        .m_rx     (m_rx),
        .m_start  (m_start),
        .m_data   (m_data),
        .m_slave  (m_slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub master: m_done pulses stub_delay cycles after the m_start cycle
    // (never if stub_delay <= 0); stub_early adds a stray pulse during START.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    m_done = 1'b1;
                    m_rx   = stub_rx;
                end
            end
            if (m_start) begin
                if (stub_delay > 0) stub_cnt = stub_delay;
                if (stub_early) begin
                    m_done = 1'b1;
                    m_rx   = 8'hEE;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete requester transaction with every observable checked.
    task automatic check_xfer(input string tag, input logic [1:0] r,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic s0, input logic s1,
                              input int dly, input logic [7:0] rx,
                              input logic [1:0] e_ack, input logic [7:0] e_data,
                              input logic e_slave, input logic [7:0] e_rx,
                              input logic e_err);
        int         iss, st, ak, e_lat;
        logic [7:0] sd, arx;
        logic       ss, aerr;
        logic [1:0] a;
        bit         stable, busy_ok, seen;
        @(negedge clk);
        tx_data0 = d0; tx_data1 = d1; slave0 = s0; slave1 = s1;
        stub_delay = dly; stub_rx = rx; req = r;
        iss = cyc; st = -1; ak = -1; stable = 1'b1; busy_ok = 1'b1; seen = 1'b0;
        sd = 8'h00; ss = 1'b0; a = 2'b00; arx = 8'h00; aerr = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (m_start) begin
                st = cyc; sd = m_data; ss = m_slave;
            end
            if (st >= 0) begin
                if (m_slave !== ss || m_data !== sd) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            if (ack !== 2'b00) begin
                seen = 1'b1; ak = cyc; a = ack; arx = rx_data; aerr = err;
            end
        end
        req = 2'b00;
        e_lat = e_err ? T + 2 : dly + 1;
        chk({tag, "_acked"},     32'(seen), 32'd1);
        chk({tag, "_start_lat"}, st - iss, 1);
        chk({tag, "_m_data"},    sd, e_data);
        chk({tag, "_m_slave"},   ss, e_slave);
        chk({tag, "_held"},      32'(stable), 32'd1);
        chk({tag, "_busy"},      32'(busy_ok), 32'd1);
        chk({tag, "_ack"},       a, e_ack);
        chk({tag, "_rx"},        arx, e_rx);
        chk({tag, "_err"},       aerr, e_err);
        chk({tag, "_ack_lat"},   ak - st, e_lat);
    endtask

    typedef struct {
        logic [1:0] r;
        logic [7:0] d0, d1;
        logic       s0, s1;
        int         dly;
        logic [7:0] rx;
        logic [1:0] e_ack;
        logic [7:0] e_data;
        logic       e_slave;
        logic [7:0] e_rx;
        logic       e_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         starts, k, rise, nst;
        int         st_cyc[4];
        logic [7:0] sdat[4];
        logic [1:0] aseq[4];
        logic [7:0] arx[4];
        bit         anyack, mlast, w, ee;
        logic [1:0] r;
        logic [7:0] d0, d1, rx;
        logic       s0, s1;
        int         dly;

        // Entries follow the pointer history from contention (last = 1 at v0).
        vecs[0] = '{2'b01, 8'hA5, 8'h00, 1'b0, 1'b0, 12, 8'h3C, 2'b01, 8'hA5, 1'b0, 8'h3C, 1'b0};
        vecs[1] = '{2'b10, 8'h00, 8'h5A, 1'b0, 1'b1,  3, 8'hC3, 2'b10, 8'h5A, 1'b1, 8'hC3, 1'b0};
        vecs[2] = '{2'b11, 8'h11, 8'h22, 1'b1, 1'b0,  1, 8'h7E, 2'b01, 8'h11, 1'b1, 8'h7E, 1'b0};
        vecs[3] = '{2'b11, 8'h33, 8'h44, 1'b1, 1'b0, 17, 8'h99, 2'b10, 8'h44, 1'b0, 8'h99, 1'b0};
        vecs[4] = '{2'b01, 8'h66, 8'h00, 1'b0, 1'b0, 18, 8'hAA, 2'b01, 8'h66, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{2'b10, 8'h00, 8'hF0, 1'b0, 1'b1, -1, 8'hBB, 2'b10, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{2'b01, 8'h0F, 8'h00, 1'b0, 1'b0, 16, 8'h55, 2'b01, 8'h0F, 1'b0, 8'h55, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_m_slave", m_slave, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Contention with both requests held: 0,1,0,1.
        tx_data0 = 8'h11; tx_data1 = 8'h22; slave0 = 1'b0; slave1 = 1'b1;
        stub_delay = 4; stub_rx = 8'h40; req = 2'b11;
        starts = 0; k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            if (m_start) begin
                if (starts < 4) begin
                    sdat[starts] = m_data; st_cyc[starts] = cyc;
                end
                starts++;
            end
            if (ack !== 2'b00) begin
                aseq[k] = ack; arx[k] = rx_data; k++;
                if (k == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("cont_acks", k, 4);
        chk("cont_starts", starts, 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("cont_data%0d", j), sdat[j], (j % 2 == 0) ? 8'h11 : 8'h22);
            chk($sformatf("cont_ack%0d", j), aseq[j], (j % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont_rx%0d", j), arx[j], 8'h40);
        end
        for (int j = 1; j < 4; j++) begin
            chk($sformatf("cont_gap%0d", j), st_cyc[j] - st_cyc[j-1], 4 + 3);
        end

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            check_xfer($sformatf("v%0d", i), vecs[i].r, vecs[i].d0, vecs[i].d1,
                       vecs[i].s0, vecs[i].s1, vecs[i].dly, vecs[i].rx,
                       vecs[i].e_ack, vecs[i].e_data, vecs[i].e_slave,
                       vecs[i].e_rx, vecs[i].e_err);
        end

        // m_ready low stalls arbitration without losing the request.
        @(negedge clk);
        m_ready = 1'b0; tx_data0 = 8'h77; slave0 = 1'b0;
        stub_delay = 2; stub_rx = 8'h21; req = 2'b01;
        nst = 0;
        repeat (50) begin
            @(negedge clk);
            if (m_start) nst++;
        end
        chk("stall_no_start", nst, 0);
        chk("stall_busy", busy, 1'b0);
        m_ready = 1'b1; rise = cyc;
        starts = -1; anyack = 1'b0; d0 = 8'h00; rx = 8'h00;
        for (int i = 0; i < 20 && !anyack; i++) begin
            @(negedge clk);
            if (m_start) begin
                starts = cyc; d0 = m_data;
            end
            if (ack !== 2'b00) begin
                anyack = 1'b1; r = ack; rx = rx_data;
            end
        end
        req = 2'b00;
        chk("stall_start_lat", starts - rise, 1);
        chk("stall_m_data", d0, 8'h77);
        chk("stall_acked", 32'(anyack), 32'd1);
        chk("stall_rx", rx, 8'h21);

        // Timeout; busy drops the cycle after the error ack.
        check_xfer("tmo", 2'b01, 8'hC0, 8'h00, 1'b1, 1'b0, -1, 8'h00,
                   2'b01, 8'hC0, 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        chk("tmo_busy_after", busy, 1'b0);

        // A stray m_done during START must be ignored.
        stub_early = 1'b1;
        check_xfer("early", 2'b01, 8'h3A, 8'h00, 1'b0, 1'b0, 4, 8'h12,
                   2'b01, 8'h3A, 1'b0, 8'h12, 1'b0);
        stub_early = 1'b0;

        // Reset in the middle of WAIT (pointer is 0 beforehand).
        @(negedge clk);
        tx_data1 = 8'hBE; slave1 = 1'b1; stub_delay = -1; req = 2'b10;
        repeat (6) @(negedge clk);
        chk("mid_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack", ack, 2'b00);
        chk("mid_err", err, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_m_start", m_start, 1'b0);
        chk("mid_m_data", m_data, 8'h00);
        chk("mid_m_slave", m_slave, 1'b0);
        chk("mid_rx_data", rx_data, 8'h00);
        req = 2'b00;
        anyack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack !== 2'b00) anyack = 1'b1;
        end
        chk("mid_no_ack", 32'(anyack), 32'd0);
        rst_n = 1'b1;
        check_xfer("post_rst", 2'b11, 8'h5C, 8'hC5, 1'b0, 1'b1, 3, 8'h81,
                   2'b01, 8'h5C, 1'b0, 8'h81, 1'b0);

        // Randomized transactions against a rule-level model.
        mlast = 1'b0;
        for (int n = 0; n < 60; n++) begin
            r   = 2'($urandom_range(1, 3));
            d0  = 8'($urandom); d1 = 8'($urandom);
            s0  = 1'($urandom); s1 = 1'($urandom);
            rx  = 8'($urandom);
            dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 20));
            w   = (r == 2'b11) ? !mlast : (r == 2'b10);
            ee  = (dly <= 0) || (dly > T + 1);
            check_xfer($sformatf("rnd%0d", n), r, d0, d1, s0, s1, dly, rx,
                       w ? 2'b10 : 2'b01, w ? d1 : d0, w ? s1 : s0,
                       ee ? 8'h00 : rx, ee);
            mlast = w;
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
